dma_dev_arbiter: RTL and testbench

- Shares one dma_controller between N_DEV peripheral devices, using round-robin arbitration.
- Sits between the devices and the dma_controller device interface.
  - Forwards the winning device's request and transfer descriptor (num_words, start_addr, rd_wr) to the DMA.
  - Routes the data and handshake signals between the DMA and the granted device only.
  - Holds the grant until the DMA's end_flag, then releases.
- The OpenMSP430 side of the DMA is unaffected.

---
 rtl/dma_dev_arbiter_pkg.sv | 17 +
 rtl/dma_dev_arbiter_rr_picker.sv | 34 +++
 rtl/dma_dev_arbiter.sv | 132 +++++++++++++
 tb/tb_dma_dev_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_dev_arbiter_pkg.sv
// Shared definitions for the DMA device arbiter: FSM encodings and the
// default bus widths it shares with dma_controller.
package dma_dev_arbiter_pkg;

    localparam int DMA_ADD_LEN  = 16;
    localparam int DMA_DATA_LEN = 16;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ARB         = 3'd1,
        ST_ISSUE       = 3'd2,
        ST_WAIT_ACCEPT = 3'd3,
        ST_BUSY        = 3'd4,
        ST_RELEASE     = 3'd5
    } arb_state_e;

endpackage

// File: rtl/dma_dev_arbiter_rr_picker.sv
// Combinational round-robin selector: first set bit of elig, scanning
// upward from rr_ptr and wrapping at N_DEV.
module dma_dev_arbiter_rr_picker #(
    parameter int N_DEV = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_DEV-1:0] elig,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [ID_W-1:0]  winner,
    output logic             any_valid
);

    logic [ID_W:0] idx;
    logic          found;

    always_comb begin
        winner    = '0;
        found     = 1'b0;
        idx       = '0;
        any_valid = |elig;
        for (int k = 0; k < N_DEV; k++) begin
            idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            // N_DEV need not be a power of two, so wrap explicitly
            if (32'(idx) >= N_DEV) begin
                idx = idx - (ID_W+1)'(N_DEV);
            end
            if (!found && elig[idx]) begin
                winner = idx[ID_W-1:0];
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_dev_arbiter.sv
// Round-robin arbiter sharing one dma_controller device port between N_DEV
// devices; the grant is held from ISSUE until the DMA's end_flag.
module dma_dev_arbiter
    import dma_dev_arbiter_pkg::*;
#(
    parameter int N_DEV    = 4,
    parameter int ID_W     = 2,
    parameter int ADD_LEN  = DMA_ADD_LEN,
    parameter int DATA_LEN = DMA_DATA_LEN
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_DEV-1:0]            dev_rqst,
    input  logic [N_DEV-1:0]            dev_en_mask,
    input  logic [N_DEV*ADD_LEN-1:0]    dev_num_words,
    input  logic [N_DEV*(ADD_LEN+1)-1:0] dev_start_addr,
    input  logic [N_DEV-1:0]            dev_rd_wr,
    input  logic [N_DEV-1:0]            dev_ack_in,
    input  logic [N_DEV*DATA_LEN-1:0]   dev_data_in,
    output logic [N_DEV-1:0]            dev_dma_ack,
    output logic [N_DEV-1:0]            dev_end_flag,
    output logic [DATA_LEN-1:0]         dev_data_out,
    output logic                        dma_rqst,
    output logic [ADD_LEN-1:0]          dma_num_words,
    output logic [ADD_LEN:0]            dma_start_addr,
    output logic                        dma_rd_wr,
    output logic                        dma_dev_ack,
    output logic [DATA_LEN-1:0]         dma_dev_in,
    input  logic                        dma_ack_in,
    input  logic                        dma_end_flag,
    input  logic [DATA_LEN-1:0]         dma_dev_out,
    output logic                        busy,
    output logic [ID_W-1:0]             grant_id,
    output arb_state_e                  dbg_state
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_DEV - 1);

    arb_state_e        state;
    logic [ID_W-1:0]   rr_ptr;
    logic [N_DEV-1:0]  elig;
    logic [ID_W-1:0]   winner;
    logic              any_valid;
    int unsigned       gsel;

    assign elig      = dev_rqst & dev_en_mask;
    assign dbg_state = state;

    dma_dev_arbiter_rr_picker #(
        .N_DEV (N_DEV),
        .ID_W  (ID_W)
    ) u_picker (
        .elig      (elig),
        .rr_ptr    (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            dma_rqst <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_valid) state <= ST_ARB;
                end
                ST_ARB: begin
                    grant_id <= winner;
                    // Requests may have vanished since IDLE; fall back quietly
                    if (any_valid) begin
                        state    <= ST_ISSUE;
                        dma_rqst <= 1'b1;
                        busy     <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    dma_rqst <= 1'b0;
                    state    <= ST_WAIT_ACCEPT;
                end
                ST_WAIT_ACCEPT: begin
                    state <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (dma_end_flag) state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    dma_rqst <= 1'b0;
                end
            endcase
        end
    end

    // Data and ack paths stay purely combinational so the DMA's
    // cycle-level handshake reaches the granted device unchanged.
    always_comb begin
        gsel           = 32'(grant_id);
        dma_num_words  = '0;
        dma_start_addr = '0;
        dma_rd_wr      = 1'b0;
        dma_dev_ack    = 1'b0;
        dma_dev_in     = '0;
        dev_dma_ack    = '0;
        dev_end_flag   = '0;
        if (busy) begin
            dma_num_words          = dev_num_words[gsel*ADD_LEN +: ADD_LEN];
            dma_start_addr         = dev_start_addr[gsel*(ADD_LEN+1) +: ADD_LEN+1];
            dma_rd_wr              = dev_rd_wr[grant_id];
            dev_dma_ack[grant_id]  = dma_ack_in;
            dev_end_flag[grant_id] = dma_end_flag;
        end
        if (state == ST_BUSY) begin
            dma_dev_ack = dev_ack_in[grant_id];
            dma_dev_in  = dev_data_in[gsel*DATA_LEN +: DATA_LEN];
        end
    end

    assign dev_data_out = dma_dev_out;

endmodule

// File: tb/tb_dma_dev_arbiter.sv
// Directed bench for dma_dev_arbiter with a small DMA-side responder and a
// queue of expected grant ids / write data.
module tb_dma_dev_arbiter;
    import dma_dev_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic [N-1:0]        dev_rqst, dev_en_mask, dev_rd_wr, dev_ack_in;
    logic [N-1:0]        dev_dma_ack, dev_end_flag;
    logic [N*AW-1:0]     dev_num_words;
    logic [N*(AW+1)-1:0] dev_start_addr;
    logic [N*DW-1:0]     dev_data_in;
    logic [DW-1:0]       dev_data_out, dma_dev_in, dma_dev_out;
    logic                dma_rqst, dma_rd_wr, dma_dev_ack, dma_ack_in, dma_end_flag, busy;
    logic [AW-1:0]       dma_num_words;
    logic [AW:0]         dma_start_addr;
    logic [1:0]          grant_id;
    arb_state_e          dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int idle_run = 0;

    logic [1:0]    exp_q[$];
    logic [DW-1:0] exp_d_q[$];
    logic [AW-1:0] nw[N];
    logic [AW:0]   sa[N];
    logic [DW-1:0] wr_words[3];

    always #5 clk = ~clk;

    dma_dev_arbiter #(.N_DEV(N), .ID_W(2), .ADD_LEN(AW), .DATA_LEN(DW)) dut (
        .clk(clk), .reset(reset),
        .dev_rqst(dev_rqst), .dev_en_mask(dev_en_mask),
        .dev_num_words(dev_num_words), .dev_start_addr(dev_start_addr),
        .dev_rd_wr(dev_rd_wr), .dev_ack_in(dev_ack_in), .dev_data_in(dev_data_in),
        .dev_dma_ack(dev_dma_ack), .dev_end_flag(dev_end_flag), .dev_data_out(dev_data_out),
        .dma_rqst(dma_rqst), .dma_num_words(dma_num_words), .dma_start_addr(dma_start_addr),
        .dma_rd_wr(dma_rd_wr), .dma_dev_ack(dma_dev_ack), .dma_dev_in(dma_dev_in),
        .dma_ack_in(dma_ack_in), .dma_end_flag(dma_end_flag), .dma_dev_out(dma_dev_out),
        .busy(busy), .grant_id(grant_id), .dbg_state(dbg_state)
    );

    task automatic finish_test();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Steps to the next ISSUE cycle; counts idle cycles seen on the way.
    task automatic wait_issue(input bit chk_gap);
        int n = 0;
        while (!dma_rqst && n < 40) begin
            @(negedge clk);
            n++;
            if (!dma_rqst && !busy) idle_run++;
        end
        if (!dma_rqst) begin
            n_checks++;
            n_fail++;
            $error("FAIL issue_timeout observed=0 expected=1");
            finish_test();
        end
        if (chk_gap) check("grant_gap_ge2", 32'(idle_run >= 2), 32'd1);
    endtask

    // Plays the DMA side of one transfer, starting in the ISSUE cycle.
    task automatic serve(input int g, input bit drop_in_busy);
        logic [DW-1:0] rd_val;
        logic          wr;
        wr = !dev_rd_wr[g];
        check("issue_rqst",  32'(dma_rqst), 32'd1);
        check("issue_grant", 32'(grant_id), 32'(g));
        check("issue_busy",  32'(busy), 32'd1);
        check("issue_nw",    32'(dma_num_words), 32'(nw[g]));
        check("issue_sa",    32'(dma_start_addr), 32'(sa[g]));
        check("issue_rdwr",  32'(dma_rd_wr), 32'(!wr));
        dev_ack_in = '1;
        #1 check("issue_ack_gated", 32'(dma_dev_ack), 32'd0);
        dev_ack_in = '0;
        @(negedge clk);
        check("wait_rqst_low", 32'(dma_rqst), 32'd0);
        @(negedge clk);
        check("busy_state", 32'(dbg_state), 32'd4);
        if (drop_in_busy) begin
            dev_rqst[g]    = 1'b0;
            dev_en_mask[g] = 1'b0;
        end
        for (int k = 0; k < int'(nw[g]); k++) begin
            rd_val      = 16'($urandom_range(0, 16'hFFFF));
            dma_dev_out = rd_val;
            dma_ack_in  = 1'b1;
            dev_data_in = {$urandom, $urandom};
            if (wr) begin
                dev_data_in[g*DW +: DW] = wr_words[k];
                dev_ack_in[g]           = 1'b1;
                exp_d_q.push_back(wr_words[k]);
            end
            #1;
            check("ack_route",  32'(dev_dma_ack), 32'd1 << g);
            check("data_bcast", 32'(dev_data_out), 32'(rd_val));
            check("busy_nw",    32'(dma_num_words), 32'(nw[g]));
            check("busy_sa",    32'(dma_start_addr), 32'(sa[g]));
            if (wr) begin
                check("dev_ack_fwd", 32'(dma_dev_ack), 32'd1);
                check("dev_in",      32'(dma_dev_in), 32'(exp_d_q.pop_front()));
            end
            @(negedge clk);
            dma_ack_in = 1'b0;
            dev_ack_in = '0;
        end
        dma_end_flag = 1'b1;
        #1 check("end_route", 32'(dev_end_flag), 32'd1 << g);
        @(negedge clk);
        dma_end_flag = 1'b0;
        check("release_state", 32'(dbg_state), 32'd5);
        check("release_busy",  32'(busy), 32'd1);
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_nw",   32'(dma_num_words), 32'd0);
        idle_run = 1;
    endtask

    initial begin : watchdog
        #500000;
        n_checks++;
        n_fail++;
        $error("FAIL watchdog observed=timeout expected=finish");
        finish_test();
    end

    initial begin
        logic saw;
        nw[0] = 16'd2; sa[0] = 17'h00040;
        nw[1] = 16'd3; sa[1] = 17'h01000;
        nw[2] = 16'd4; sa[2] = 17'h00100;
        nw[3] = 16'd2; sa[3] = 17'h18000;
        wr_words[0] = 16'hA5A5; wr_words[1] = 16'h5A5A; wr_words[2] = 16'h1234;
        for (int i = 0; i < N; i++) begin
            dev_num_words[i*AW +: AW]         = nw[i];
            dev_start_addr[i*(AW+1) +: AW+1] = sa[i];
        end
        dev_rd_wr    = 4'b1101;
        reset        = 1'b1;
        dev_rqst     = '0;
        dev_en_mask  = '1;
        dev_ack_in   = '1;
        dev_data_in  = '1;
        dma_ack_in   = 1'b1;
        dma_end_flag = 1'b1;
        dma_dev_out  = '0;

        repeat (3) @(negedge clk);
        check("rst_state",     32'(dbg_state), 32'd0);
        check("rst_busy",      32'(busy), 32'd0);
        check("rst_rqst",      32'(dma_rqst), 32'd0);
        check("rst_grant",     32'(grant_id), 32'd0);
        check("rst_dev_ack",   32'(dev_dma_ack), 32'd0);
        check("rst_dev_end",   32'(dev_end_flag), 32'd0);
        check("rst_dma_ack",   32'(dma_dev_ack), 32'd0);
        check("rst_desc",      32'({dma_num_words, dma_start_addr[15:0]}), 32'd0);
        check("rst_addr_rdwr", 32'({dma_start_addr[16], dma_rd_wr}), 32'd0);
        check("rst_dev_in",    32'(dma_dev_in), 32'd0);
        dev_ack_in   = '0;
        dev_data_in  = '0;
        dma_ack_in   = 1'b0;
        dma_end_flag = 1'b0;
        reset        = 1'b0;
        @(negedge clk);

        // Stray end_flag while idle must not move the FSM or reach a device.
        dma_end_flag = 1'b1;
        #1 check("idle_end_route", 32'(dev_end_flag), 32'd0);
        @(negedge clk);
        dma_end_flag = 1'b0;
        check("idle_end_ignored", 32'(dbg_state), 32'd0);

        // Single device 2 read. The request is presented after edge 1, so
        // edge 2 enters ARB and edge 3 enters ISSUE with dma_rqst high.
        dev_rqst = 4'b0100;
        @(negedge clk);
        check("lat_arb_state", 32'(dbg_state), 32'd1);
        check("lat_rqst_low",  32'(dma_rqst), 32'd0);
        @(negedge clk);
        check("lat_rqst_high", 32'(dma_rqst), 32'd1);
        dev_rqst = '0;
        serve(2, 1'b0);

        // rr_ptr is now 3: device 3 must beat device 0, then device 0 follows.
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        dev_rqst = 4'b1001;
        for (int i = 0; i < 2; i++) begin
            wait_issue(i > 0);
            dev_rqst = (i == 0) ? 4'b0001 : 4'b0000;
            serve(int'(exp_q.pop_front()), 1'b0);
        end

        // Reset mid-BUSY aborts the grant and clears the pointer.
        dev_rqst = 4'b1000;
        wait_issue(1'b0);
        check("rst_mid_grant", 32'(grant_id), 32'd3);
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_busy_state", 32'(dbg_state), 32'd4);
        dma_ack_in = 1'b1;
        #1 check("rst_mid_ack_route", 32'(dev_dma_ack), 32'b1000);
        reset = 1'b1;
        #1;
        check("rst_mid_busy",  32'(busy), 32'd0);
        check("rst_mid_rqst",  32'(dma_rqst), 32'd0);
        check("rst_mid_ack",   32'(dev_dma_ack), 32'd0);
        check("rst_mid_nw",    32'(dma_num_words), 32'd0);
        check("rst_mid_state", 32'(dbg_state), 32'd0);
        dev_rqst = '0;
        @(negedge clk);
        check("rst_mid_gid", 32'(grant_id), 32'd0);
        dma_ack_in = 1'b0;
        reset      = 1'b0;
        @(negedge clk);

        // Devices 0,1,3 hold requests: rotation from pointer 0.
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        dev_rqst = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            wait_issue(i > 0);
            if (i == 3) dev_rqst = '0;
            serve(int'(exp_q.pop_front()), 1'b0);
        end

        // Device 1 three-word write.
        exp_q.push_back(2'd1);
        dev_rqst = 4'b0010;
        wait_issue(1'b0);
        dev_rqst = '0;
        serve(int'(exp_q.pop_front()), 1'b0);

        // Device 2 masked off while all four request.
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        dev_en_mask = 4'b1011;
        dev_rqst    = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_issue(i > 0);
            if (i == 3) dev_rqst = '0;
            serve(int'(exp_q.pop_front()), 1'b0);
        end
        dev_en_mask = '1;

        // Device 0 drops its request and mask during BUSY: no re-issue.
        exp_q.push_back(2'd0);
        dev_rqst = 4'b0001;
        wait_issue(1'b0);
        serve(int'(exp_q.pop_front()), 1'b1);
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            saw = saw | dma_rqst | busy;
        end
        check("drop_no_reissue", 32'(saw), 32'd0);
        check("drop_idle_state", 32'(dbg_state), 32'd0);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        finish_test();
    end

endmodule
